empaquetador_nibbles: RTL and testbench

- Downstream consumer of the 4-bit adder/counter stage.
- Samples the stage's Q nibble and RCO each enabled clock and packs NIBBLES consecutive results, LSB-nibble first, into one wide word.
- Presents the word on a VALIDO/RDY handshake to the next consumer (capture/serial stage).
- Assembly register plus output register give one word of slack so the adder need not stall.

---
 rtl/empaq_defs_pkg.sv | 20 ++
 rtl/registro_salida.sv | 57 +++++
 rtl/empaquetador_nibbles.sv | 138 +++++++++++++
 tb/tb_empaquetador_nibbles.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/empaq_defs_pkg.sv
// Shared definitions for the nibble packer: FSM state encoding, default sizes
// and the index-width helper.
package empaq_defs;

    typedef enum logic {
        ARMANDO = 1'b0,
        ESPERA  = 1'b1
    } estado_t;

    localparam int unsigned NIBBLES_DEF = 4;
    localparam int unsigned ANCHO_Q_DEF = 4;

    function automatic int unsigned clog2(input int unsigned valor);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < valor) r++;
        return r;
    endfunction

endpackage

// File: rtl/registro_salida.sv
// Output register of the nibble packer: holds the presented word, its carry
// (and parity when EMPAQ_PARIDAD_EN is defined) plus VALIDO.
module registro_salida #(
    parameter int unsigned ANCHO = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_carga,
    input  logic [ANCHO-1:0] i_dato,
    input  logic             i_rco,
    input  logic             i_rdy,
    output logic [ANCHO-1:0] o_dato,
    output logic             o_rco,
    output logic             o_valido
`ifdef EMPAQ_PARIDAD_EN
    ,
    output logic             o_paridad
`endif
);

    logic [ANCHO-1:0] r_dato;
    logic             r_rco;
    logic             r_valido;
`ifdef EMPAQ_PARIDAD_EN
    logic             r_paridad;
`endif

    // The parent only asserts i_carga when the slot is free, so a load always
    // wins over the clear-on-transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dato    <= '0;
            r_rco     <= 1'b0;
            r_valido  <= 1'b0;
`ifdef EMPAQ_PARIDAD_EN
            r_paridad <= 1'b0;
`endif
        end else if (i_carga) begin
            r_dato    <= i_dato;
            r_rco     <= i_rco;
            r_valido  <= 1'b1;
`ifdef EMPAQ_PARIDAD_EN
            r_paridad <= ^i_dato;
`endif
        end else if (r_valido && i_rdy) begin
            r_valido  <= 1'b0;
        end
    end

    assign o_dato   = r_dato;
    assign o_rco    = r_rco;
    assign o_valido = r_valido;
`ifdef EMPAQ_PARIDAD_EN
    assign o_paridad = r_paridad;
`endif

endmodule

// File: rtl/empaquetador_nibbles.sv
// Packs NIBBLES consecutive adder results (LSB nibble first) into one word and
// presents it on a VALIDO/RDY handshake. Optional PARIDAD output: EMPAQ_PARIDAD_EN.
module empaquetador_nibbles
    import empaq_defs::*;
#(
    parameter int unsigned NIBBLES = NIBBLES_DEF,
    parameter int unsigned ANCHO_Q = ANCHO_Q_DEF
) (
    input  logic                          CLK,
    input  logic                          RESET_L,
    input  logic                          ENB,
    input  logic [ANCHO_Q-1:0]            Q,
    input  logic                          RCO,
    input  logic                          RDY,
    output logic [NIBBLES*ANCHO_Q-1:0]    DATO,
    output logic                          VALIDO,
    output logic                          RCO_ACUM,
    output logic                          OVF,
    output logic [clog2(NIBBLES)-1:0]     INDICE
`ifdef EMPAQ_PARIDAD_EN
    ,
    output logic                          PARIDAD
`endif
);

    localparam int unsigned   W      = NIBBLES * ANCHO_Q;
    localparam int unsigned   IW     = clog2(NIBBLES);
    localparam logic [IW-1:0] ULTIMO = IW'(NIBBLES - 1);

    estado_t         r_estado, w_estado_sig;
    logic [W-1:0]    r_ensamble, w_ens_sig, w_ens_escrito;
    logic            r_carry, w_carry_sig;
    logic [IW-1:0]   r_indice, w_indice_sig;
    logic            r_ovf, w_ovf_sig;
    logic            w_carga, w_rco_carga, w_libre;
    logic [W-1:0]    w_dato_carga;

    assign w_libre = !VALIDO || RDY;

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_estado   <= ARMANDO;
            r_ensamble <= '0;
            r_carry    <= 1'b0;
            r_indice   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_estado   <= w_estado_sig;
            r_ensamble <= w_ens_sig;
            r_carry    <= w_carry_sig;
            r_indice   <= w_indice_sig;
            r_ovf      <= w_ovf_sig;
        end
    end

    always_comb begin
        w_ens_escrito = r_ensamble;
        for (int unsigned k = 0; k < NIBBLES; k++) begin
            if (r_indice == IW'(k)) w_ens_escrito[k*ANCHO_Q +: ANCHO_Q] = Q;
        end

        w_estado_sig = r_estado;
        w_ens_sig    = r_ensamble;
        w_carry_sig  = r_carry;
        w_indice_sig = r_indice;
        w_ovf_sig    = r_ovf;
        w_carga      = 1'b0;
        w_dato_carga = r_ensamble;
        w_rco_carga  = r_carry;

        case (r_estado)
            ARMANDO: begin
                if (ENB) begin
                    if (r_indice == ULTIMO) begin
                        if (w_libre) begin
                            w_carga      = 1'b1;
                            w_dato_carga = w_ens_escrito;
                            w_rco_carga  = r_carry | RCO;
                            w_ens_sig    = '0;
                            w_carry_sig  = 1'b0;
                            w_indice_sig = '0;
                        end else begin
                            w_estado_sig = ESPERA;
                            w_ens_sig    = w_ens_escrito;
                            w_carry_sig  = r_carry | RCO;
                        end
                    end else begin
                        w_ens_sig    = w_ens_escrito;
                        w_carry_sig  = r_carry | RCO;
                        w_indice_sig = r_indice + 1'b1;
                    end
                end
            end
            ESPERA: begin
                // The pending word drains on the transfer edge; a nibble on the
                // same edge starts the next word instead of being dropped.
                if (VALIDO && RDY) begin
                    w_carga      = 1'b1;
                    w_estado_sig = ARMANDO;
                    if (ENB) begin
                        w_ens_sig    = {{(W-ANCHO_Q){1'b0}}, Q};
                        w_carry_sig  = RCO;
                        w_indice_sig = IW'(1);
                    end else begin
                        w_ens_sig    = '0;
                        w_carry_sig  = 1'b0;
                        w_indice_sig = '0;
                    end
                end else if (ENB) begin
                    w_ovf_sig = 1'b1;
                end
            end
            default: w_estado_sig = ARMANDO;
        endcase
    end

    registro_salida #(
        .ANCHO (W)
    ) u_registro_salida (
        .i_clk     (CLK),
        .i_rst_n   (RESET_L),
        .i_carga   (w_carga),
        .i_dato    (w_dato_carga),
        .i_rco     (w_rco_carga),
        .i_rdy     (RDY),
        .o_dato    (DATO),
        .o_rco     (RCO_ACUM),
        .o_valido  (VALIDO)
`ifdef EMPAQ_PARIDAD_EN
        ,
        .o_paridad (PARIDAD)
`endif
    );

    assign INDICE = r_indice;
    assign OVF    = r_ovf;

endmodule

// File: tb/tb_empaquetador_nibbles.sv
// Directed self-checking bench for empaquetador_nibbles (NIBBLES=4, ANCHO_Q=4).
module tb_empaquetador_nibbles;

    logic        CLK = 1'b0;
    logic        RESET_L;
    logic        ENB;
    logic [3:0]  Q;
    logic        RCO;
    logic        RDY;
    logic [15:0] DATO;
    logic        VALIDO;
    logic        RCO_ACUM;
    logic        OVF;
    logic [1:0]  INDICE;
`ifdef EMPAQ_PARIDAD_EN
    logic        PARIDAD;
`endif

    int n_ok    = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    empaquetador_nibbles #(
        .NIBBLES (4),
        .ANCHO_Q (4)
    ) dut (
        .CLK      (CLK),
        .RESET_L  (RESET_L),
        .ENB      (ENB),
        .Q        (Q),
        .RCO      (RCO),
        .RDY      (RDY),
        .DATO     (DATO),
        .VALIDO   (VALIDO),
        .RCO_ACUM (RCO_ACUM),
        .OVF      (OVF),
        .INDICE   (INDICE)
`ifdef EMPAQ_PARIDAD_EN
        ,
        .PARIDAD  (PARIDAD)
`endif
    );

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_total++;
        if (obs === esp) n_ok++;
        else $display("FAIL %s: got %h expected %h", tag, obs, esp);
    endtask

    task automatic ciclo();
        @(posedge CLK);
        #1;
    endtask

    task automatic nibble(input logic [3:0] q, input logic rco);
        ENB = 1'b1;
        Q   = q;
        RCO = rco;
        ciclo();
        ENB = 1'b0;
        RCO = 1'b0;
    endtask

    task automatic palabra(input logic [15:0] w, input logic rco0);
        nibble(w[3:0], rco0);
        nibble(w[7:4], 1'b0);
        nibble(w[11:8], 1'b0);
        nibble(w[15:12], 1'b0);
    endtask

    initial begin
        RESET_L = 1'b0; ENB = 1'b0; Q = '0; RCO = 1'b0; RDY = 1'b0;
        #1;
        chequear("rst_dato",   32'(DATO),     32'h0);
        chequear("rst_valido", 32'(VALIDO),   32'h0);
        chequear("rst_indice", 32'(INDICE),   32'h0);
        chequear("rst_ovf",    32'(OVF),      32'h0);
        ciclo(); ciclo();
        RESET_L = 1'b1;
        RDY = 1'b1;

        // Basic pack
        nibble(4'h1, 1'b0); nibble(4'h2, 1'b0); nibble(4'h3, 1'b0);
        chequear("pack_indice3", 32'(INDICE),  32'd3);
        chequear("pack_novalid", 32'(VALIDO),  32'h0);
        nibble(4'h4, 1'b0);
        chequear("pack_dato",    32'(DATO),     32'h4321);
        chequear("pack_valido",  32'(VALIDO),   32'h1);
        chequear("pack_rco",     32'(RCO_ACUM), 32'h0);
        chequear("pack_wrap",    32'(INDICE),   32'h0);
        ciclo();
        chequear("pack_1ciclo",  32'(VALIDO),   32'h0);
        chequear("pack_hold",    32'(DATO),     32'h4321);

        // Carry fold, then a carry-free word right behind it
        palabra(16'h000F, 1'b1);
        chequear("carry_dato",   32'(DATO),     32'h000F);
        chequear("carry_rco1",   32'(RCO_ACUM), 32'h1);
        palabra(16'h0009, 1'b0);
        chequear("carry_dato2",  32'(DATO),     32'h0009);
        chequear("carry_rco0",   32'(RCO_ACUM), 32'h0);

        // Asynchronous reset mid-word with VALIDO held up
        RDY = 1'b0;
        nibble(4'h5, 1'b1); nibble(4'h6, 1'b0);
        chequear("mid_indice2",  32'(INDICE),   32'd2);
        chequear("mid_valido",   32'(VALIDO),   32'h1);
        ENB = 1'b1; Q = 4'h7;
        #3 RESET_L = 1'b0;
        #1;
        chequear("arst_dato",    32'(DATO),     32'h0);
        chequear("arst_valido",  32'(VALIDO),   32'h0);
        chequear("arst_indice",  32'(INDICE),   32'h0);
        chequear("arst_rco",     32'(RCO_ACUM), 32'h0);
        ENB = 1'b0;
        ciclo();
        RESET_L = 1'b1;
        RDY = 1'b1;
        palabra(16'hDCBA, 1'b0);
        chequear("arst_slot0",   32'(DATO),     32'hDCBA);
        ciclo();

        // Backpressure into ESPERA, then simultaneous drain + accept
        RDY = 1'b0;
        palabra(16'h4321, 1'b0);
        palabra(16'h8765, 1'b0);
        chequear("bp_dato",      32'(DATO),     32'h4321);
        chequear("bp_indice",    32'(INDICE),   32'd3);
        chequear("bp_ovf0",      32'(OVF),      32'h0);
        chequear("bp_estado",    32'(dut.r_estado), 32'h1);
        RDY = 1'b1;
        nibble(4'hA, 1'b0);
        chequear("sim_dato",     32'(DATO),     32'h8765);
        chequear("sim_valido",   32'(VALIDO),   32'h1);
        chequear("sim_indice",   32'(INDICE),   32'd1);
        chequear("sim_ovf",      32'(OVF),      32'h0);
        nibble(4'hB, 1'b0); nibble(4'hC, 1'b0); nibble(4'hD, 1'b0);
        chequear("sim_slot0",    32'(DATO),     32'hDCBA);
        ciclo();

        // Drop while stalled, then drain both words
        RDY = 1'b0;
        palabra(16'h4321, 1'b0);
        palabra(16'h8765, 1'b0);
        nibble(4'h9, 1'b0);
        chequear("drop_ovf",     32'(OVF),      32'h1);
        chequear("drop_dato",    32'(DATO),     32'h4321);
        chequear("drop_indice",  32'(INDICE),   32'd3);
        RDY = 1'b1;
        ciclo();
        chequear("drain_dato",   32'(DATO),     32'h8765);
        chequear("drain_valido", 32'(VALIDO),   32'h1);
        chequear("drain_indice", 32'(INDICE),   32'h0);
        ciclo();
        chequear("drain_fin",    32'(VALIDO),   32'h0);
        chequear("drain_ovf",    32'(OVF),      32'h1);

`ifdef EMPAQ_PARIDAD_EN
        palabra(16'h0007, 1'b0);
        chequear("par_impar",    32'(PARIDAD),  32'h1);
        palabra(16'h0003, 1'b0);
        chequear("par_par",      32'(PARIDAD),  32'h0);
`endif

        #3 RESET_L = 1'b0;
        #1;
        chequear("arst_ovf",     32'(OVF),      32'h0);

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end

endmodule
